conv_interleaver_core: RTL

//  Parametrised convolutional (Forney) interleaver datapath. Successor to the single-bit enable-hold register cell.

---
 rtl/intlv_pkg.sv | 23 ++
 rtl/intlv_branch_delay.sv | 61 ++++++
 rtl/conv_interleaver_core.sv | 99 +++++++++
 3 files changed

// File: rtl/intlv_pkg.sv
// -----------------------------------------------------------------------------
// intlv_pkg
//   Shared helpers for the convolutional interleaver / deinterleaver pair.
//   - clog2_safe  : index width for a commutator, never narrower than 1 bit
//   - branch_len  : number of delay cells in interleaver branch b
//   - total_cells : total delay cells across all branches (same figure for the
//                   matching deinterleaver, whose branches run in reverse)
// -----------------------------------------------------------------------------
package intlv_pkg;

  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int branch_len(input int b, input int step);
    return b * step;
  endfunction

  function automatic int total_cells(input int branches, input int step);
    return step * branches * (branches - 1) / 2;
  endfunction

endpackage

// File: rtl/intlv_branch_delay.sv
// -----------------------------------------------------------------------------
// intlv_branch_delay
//   LEN-stage enable-hold shift register forming one commutator branch.
//   LEN == 0 degenerates to a wire (tail = din).
//   Optional synchronous clear when CONV_INTLV_FLUSH_EN is defined.
// Ports
//   clk    in  1      rising-edge clock
//   reset  in  1      asynchronous, active-high reset
//   clr    in  1      synchronous clear (only with CONV_INTLV_FLUSH_EN)
//   en     in  1      advance the line one cell
//   din    in  WIDTH  symbol entering the head
//   tail   out WIDTH  oldest cell (value before the next shift)
// -----------------------------------------------------------------------------
module intlv_branch_delay #(
  parameter int WIDTH = 8,
  parameter int LEN   = 2
) (
  input  logic             clk,
  input  logic             reset,
`ifdef CONV_INTLV_FLUSH_EN
  input  logic             clr,
`endif
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tail
);

  generate
    if (LEN == 0) begin : g_wire
      logic unused_inputs;
`ifdef CONV_INTLV_FLUSH_EN
      assign unused_inputs = ^{clk, reset, en, clr};
`else
      assign unused_inputs = ^{clk, reset, en};
`endif
      assign tail = din;
    end else begin : g_line
      logic [WIDTH-1:0] cells [LEN];

      // NOTE: the cells are discrete flops, so resetting the whole array is
      // legal and cheap; a RAM-style array would not accept an async reset.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < LEN; i++) cells[i] <= '0;
`ifdef CONV_INTLV_FLUSH_EN
        end else if (clr) begin
          for (int i = 0; i < LEN; i++) cells[i] <= '0;
`endif
        end else if (en) begin
          // NOTE: non-blocking assignments let every cell sample its
          // neighbour's old value, giving a true shift rather than a smear.
          cells[0] <= din;
          for (int i = 1; i < LEN; i++) cells[i] <= cells[i-1];
        end
      end

      assign tail = cells[LEN-1];
    end
  endgenerate

endmodule

// File: rtl/conv_interleaver_core.sv
// -----------------------------------------------------------------------------
// conv_interleaver_core
//   Forney convolutional interleaver datapath. Input symbols are commutated
//   over BRANCHES delay lines; branch b delays by b*DEPTH_STEP visits.
//   Optional feature macro: CONV_INTLV_FLUSH_EN (adds synchronous flush port).
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   flush      in   1      synchronous clear of all state (CONV_INTLV_FLUSH_EN)
//   in_valid   in   1      input symbol strobe
//   in_data    in   WIDTH  input symbol
//   out_valid  out  1      high one cycle after each accepted input
//   out_data   out  WIDTH  interleaved symbol (held while idle)
//   branch_idx out  BW     branch that will take the next input
// -----------------------------------------------------------------------------
module conv_interleaver_core
  import intlv_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  int BRANCHES   = 4,
  parameter  int DEPTH_STEP = 2,
  localparam int BW         = clog2_safe(BRANCHES)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef CONV_INTLV_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [BW-1:0]    branch_idx
);

  logic [BW-1:0]    comm;
  logic [BRANCHES-1:0] en;
  logic [WIDTH-1:0] tails [BRANCHES];
  logic [WIDTH-1:0] tail_sel;
  logic             clear;

`ifdef CONV_INTLV_FLUSH_EN
  assign clear = flush;
`else
  assign clear = 1'b0;
`endif

  genvar b;
  generate
    for (b = 0; b < BRANCHES; b++) begin : g_branch
      // Only the selected branch shifts; all others hold their contents.
      assign en[b] = in_valid && !clear && (comm == BW'(b));

      intlv_branch_delay #(
        .WIDTH (WIDTH),
        .LEN   (branch_len(b, DEPTH_STEP))
      ) u_delay (
        .clk   (clk),
        .reset (reset),
`ifdef CONV_INTLV_FLUSH_EN
        .clr   (flush),
`endif
        .en    (en[b]),
        .din   (in_data),
        .tail  (tails[b])
      );
    end
  endgenerate

  // NOTE: default assignment first so no path through the mux leaves
  // tail_sel unassigned, which would otherwise infer a latch.
  always_comb begin
    tail_sel = '0;
    for (int i = 0; i < BRANCHES; i++) begin
      if (comm == BW'(i)) tail_sel = tails[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      comm      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      comm      <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out_data  <= tail_sel;
      out_valid <= 1'b1;
      // Explicit wrap so non-power-of-2 branch counts never reach 2^BW-1.
      comm      <= (comm == BW'(BRANCHES - 1)) ? '0 : comm + 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign branch_idx = comm;

endmodule
